// File: rtl/multi_port_queue.sv
// Circular FIFO accepting up to ENQ_WIDTH entries and releasing up to DEQ_WIDTH entries per cycle.
// Provides an occupancy count, an almost-full flag and a combinational head-window read port.
module multi_port_queue #(
  parameter int QUEUE_WIDTH       = 32,
  parameter int QUEUE_DEPTH       = 16,
  parameter int ENQ_WIDTH         = 2,
  parameter int DEQ_WIDTH         = 2,
  parameter int ALMOST_FULL_SLACK = 2,
  localparam int PTR_W = $clog2(QUEUE_DEPTH) + 1,
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1),
  localparam int EC_W  = $clog2(ENQ_WIDTH + 1),
  localparam int DC_W  = $clog2(DEQ_WIDTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic [EC_W-1:0]                       enq_count,
  input  logic [ENQ_WIDTH-1:0][QUEUE_WIDTH-1:0] enqueue_wdata,
  output logic                                  enq_accept,
  input  logic [DC_W-1:0]                       deq_count,
  output logic [DEQ_WIDTH-1:0][QUEUE_WIDTH-1:0] dequeue_rdata,
  output logic [DEQ_WIDTH-1:0]                  dequeue_valid,
  output logic [CNT_W-1:0]                      count,
  output logic                                  is_empty,
  output logic                                  is_full,
  output logic                                  almost_full
);

  localparam int IDX_W = PTR_W - 1;

  logic [PTR_W-1:0]       head_q, head_d;
  logic [PTR_W-1:0]       tail_q, tail_d;
  logic [QUEUE_WIDTH-1:0] mem_q [QUEUE_DEPTH];
  logic [QUEUE_WIDTH-1:0] mem_d [QUEUE_DEPTH];

  logic [PTR_W-1:0] occ;
  logic [PTR_W-1:0] deq_ext;
  logic [PTR_W-1:0] popped;
  logic [CNT_W-1:0] free_slots;

  // The wrap bit makes tail - head span 0..QUEUE_DEPTH without ambiguity.
  assign occ        = tail_q - head_q;
  assign count      = CNT_W'(occ);
  assign free_slots = CNT_W'(QUEUE_DEPTH) - count;
  assign is_empty   = (count == '0);
  assign is_full    = (count == CNT_W'(QUEUE_DEPTH));
  assign almost_full = (32'(free_slots) < 32'(ALMOST_FULL_SLACK));

  // Room is judged before any same-cycle pop; out-of-range offers are never accepted.
  assign enq_accept = !flush && (enq_count != '0)
                      && (32'(enq_count) <= 32'(ENQ_WIDTH))
                      && (32'(enq_count) <= 32'(free_slots));

  assign deq_ext = PTR_W'(deq_count);
  assign popped  = (deq_ext < occ) ? deq_ext : occ;

  always_comb begin
    head_d = head_q + popped;
    tail_d = enq_accept ? tail_q + PTR_W'(enq_count) : tail_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // Storage is deliberately left out of reset; only the pointers define validity.
  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      if (enq_accept && (k < int'(enq_count))) begin
        mem_d[tail_q[IDX_W-1:0] + IDX_W'(k)] = enqueue_wdata[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    dequeue_rdata = '0;
    dequeue_valid = '0;
    for (int i = 0; i < DEQ_WIDTH; i++) begin
      if (count > CNT_W'(i)) begin
        dequeue_valid[i] = 1'b1;
        dequeue_rdata[i] = mem_q[head_q[IDX_W-1:0] + IDX_W'(i)];
      end
    end
  end

  a_enq_count_legal: assert property (@(posedge clk) disable iff (rst)
    (32'(enq_count) <= 32'(ENQ_WIDTH)));

endmodule

// File: tb/tb_multi_port_queue.sv
// Directed bench for multi_port_queue at default parameters (32-bit x 16 entries, 2-in / 2-out).
module tb_multi_port_queue;

  logic             clk;
  logic             rst;
  logic             flush;
  logic [1:0]       enq_count;
  logic [1:0][31:0] enqueue_wdata;
  logic             enq_accept;
  logic [1:0]       deq_count;
  logic [1:0][31:0] dequeue_rdata;
  logic [1:0]       dequeue_valid;
  logic [4:0]       count;
  logic             is_empty;
  logic             is_full;
  logic             almost_full;

  int vectors;
  int miscompares;

  multi_port_queue dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .enq_count     (enq_count),
    .enqueue_wdata (enqueue_wdata),
    .enq_accept    (enq_accept),
    .deq_count     (deq_count),
    .dequeue_rdata (dequeue_rdata),
    .dequeue_valid (dequeue_valid),
    .count         (count),
    .is_empty      (is_empty),
    .is_full       (is_full),
    .almost_full   (almost_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    flush = 1'b0;
    enq_count = 2'd0;
    deq_count = 2'd0;
    enqueue_wdata = '0;

    // Reset state
    #3;
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(is_empty), 32'd1);
    check("rst_full", 32'(is_full), 32'd0);
    check("rst_afull", 32'(almost_full), 32'd0);
    check("rst_valid", 32'(dequeue_valid), 32'd0);
    check("rst_rdata0", dequeue_rdata[0], 32'd0);
    check("rst_rdata1", dequeue_rdata[1], 32'd0);
    check("rst_accept0", 32'(enq_accept), 32'd0);
    enq_count = 2'd2;
    #1;
    check("rst_accept2", 32'(enq_accept), 32'd1);
    enq_count = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    tick();

    // Fill with pairs A0..AF
    for (int j = 0; j < 8; j++) begin
      enq_count = 2'd2;
      enqueue_wdata[0] = 32'hA0 + 32'(2 * j);
      enqueue_wdata[1] = 32'hA1 + 32'(2 * j);
      #1;
      check("fill_accept", 32'(enq_accept), 32'd1);
      tick();
      check("fill_count", 32'(count), 32'(2 * (j + 1)));
      check("fill_afull", 32'(almost_full), (2 * (j + 1) >= 15) ? 32'd1 : 32'd0);
    end
    check("fill_full", 32'(is_full), 32'd1);
    enqueue_wdata[0] = 32'hEE;
    enqueue_wdata[1] = 32'hEF;
    #1;
    check("full_reject", 32'(enq_accept), 32'd0);
    tick();
    check("full_hold_count", 32'(count), 32'd16);
    enq_count = 2'd0;

    // Drain in order
    deq_count = 2'd2;
    for (int j = 0; j < 8; j++) begin
      #1;
      check("drain_lane0", dequeue_rdata[0], 32'hA0 + 32'(2 * j));
      check("drain_lane1", dequeue_rdata[1], 32'hA1 + 32'(2 * j));
      check("drain_valid", 32'(dequeue_valid), 32'h3);
      tick();
      check("drain_count", 32'(count), 32'(16 - 2 * (j + 1)));
    end
    deq_count = 2'd0;
    #1;
    check("drain_empty", 32'(is_empty), 32'd1);
    check("drain_valid0", 32'(dequeue_valid), 32'd0);
    check("drain_rdata0", dequeue_rdata[0], 32'd0);

    // Fill to 15 entries: C0..CE
    for (int j = 0; j < 7; j++) begin
      enq_count = 2'd2;
      enqueue_wdata[0] = 32'hC0 + 32'(2 * j);
      enqueue_wdata[1] = 32'hC1 + 32'(2 * j);
      tick();
    end
    enq_count = 2'd1;
    enqueue_wdata[0] = 32'hCE;
    tick();
    check("c15_count", 32'(count), 32'd15);
    check("c15_afull", 32'(almost_full), 32'd1);
    check("c15_full", 32'(is_full), 32'd0);
    enq_count = 2'd2;
    enqueue_wdata[0] = 32'hF0;
    enqueue_wdata[1] = 32'hF1;
    #1;
    check("c15_reject", 32'(enq_accept), 32'd0);
    tick();
    check("c15_hold", 32'(count), 32'd15);
    deq_count = 2'd2;
    #1;
    check("c15_pop_reject", 32'(enq_accept), 32'd0);
    tick();
    enq_count = 2'd0;
    deq_count = 2'd0;
    #1;
    check("c15_pop_count", 32'(count), 32'd13);
    check("c15_pop_head", dequeue_rdata[0], 32'hC2);

    // Drain 13 entries so head and tail sit at index 15
    deq_count = 2'd2;
    for (int j = 0; j < 6; j++) tick();
    deq_count = 2'd1;
    tick();
    deq_count = 2'd0;
    #1;
    check("pre_wrap_empty", 32'(is_empty), 32'd1);
    enq_count = 2'd2;
    enqueue_wdata[0] = 32'hB0;
    enqueue_wdata[1] = 32'hB1;
    #1;
    check("wrap_accept", 32'(enq_accept), 32'd1);
    check("wrap_no_bypass", 32'(dequeue_valid), 32'd0);
    tick();
    enq_count = 2'd0;
    #1;
    check("wrap_count", 32'(count), 32'd2);
    check("wrap_lane0", dequeue_rdata[0], 32'hB0);
    check("wrap_lane1", dequeue_rdata[1], 32'hB1);
    check("wrap_valid", 32'(dequeue_valid), 32'h3);

    // Over-request with a single entry present
    deq_count = 2'd1;
    tick();
    deq_count = 2'd2;
    #1;
    check("one_count", 32'(count), 32'd1);
    check("one_lane0", dequeue_rdata[0], 32'hB1);
    check("one_valid", 32'(dequeue_valid), 32'h1);
    check("one_lane1", dequeue_rdata[1], 32'd0);
    tick();
    deq_count = 2'd0;
    #1;
    check("over_count", 32'(count), 32'd0);
    check("over_empty", 32'(is_empty), 32'd1);
    enq_count = 2'd1;
    enqueue_wdata[0] = 32'hD0;
    tick();
    enq_count = 2'd0;
    #1;
    check("over_reuse_count", 32'(count), 32'd1);
    check("over_reuse_lane0", dequeue_rdata[0], 32'hD0);

    // Flush with count=5 and concurrent enqueue/dequeue
    enq_count = 2'd2;
    enqueue_wdata[0] = 32'hD1;
    enqueue_wdata[1] = 32'hD2;
    tick();
    enqueue_wdata[0] = 32'hD3;
    enqueue_wdata[1] = 32'hD4;
    tick();
    check("pre_flush_count", 32'(count), 32'd5);
    flush = 1'b1;
    deq_count = 2'd1;
    enqueue_wdata[0] = 32'hE0;
    enqueue_wdata[1] = 32'hE1;
    #1;
    check("flush_accept", 32'(enq_accept), 32'd0);
    tick();
    flush = 1'b0;
    enq_count = 2'd0;
    deq_count = 2'd0;
    #1;
    check("flush_count", 32'(count), 32'd0);
    check("flush_empty", 32'(is_empty), 32'd1);
    check("flush_valid", 32'(dequeue_valid), 32'd0);

    // Asynchronous reset between edges
    enq_count = 2'd2;
    enqueue_wdata[0] = 32'h11;
    enqueue_wdata[1] = 32'h22;
    tick();
    enq_count = 2'd0;
    #1;
    check("pre_arst_count", 32'(count), 32'd2);
    rst = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_empty", 32'(is_empty), 32'd1);
    check("arst_valid", 32'(dequeue_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_arst_count", 32'(count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
